// File: rtl/nv_nvdla_pdp_wdma_pack_if.sv
`timescale 1ns/1ps
// Handshake bundle between the pooling datapath, the write packer and the DMA write port.
// Valid/ready rule for both channels: a transfer happens on a rising clock edge where
// valid and ready are both high; the source holds its payload stable while valid is high
// and ready is low, and may only drop valid after the transfer.
interface nv_nvdla_pdp_wdma_pack_if;
  logic [7:0]  pdp_dp2wdma_pd;
  logic        pdp_dp2wdma_valid;
  logic        pdp_dp2wdma_ready;
  logic [95:0] dma_wr_req_pd;
  logic        dma_wr_req_valid;
  logic        dma_wr_req_ready;

  // The packer: sinks bytes, sources DMA write requests.
  modport master (
    input  pdp_dp2wdma_pd,
    input  pdp_dp2wdma_valid,
    output pdp_dp2wdma_ready,
    output dma_wr_req_pd,
    output dma_wr_req_valid,
    input  dma_wr_req_ready
  );

  // The surroundings: byte producer and DMA engine.
  modport slave (
    output pdp_dp2wdma_pd,
    output pdp_dp2wdma_valid,
    input  pdp_dp2wdma_ready,
    input  dma_wr_req_pd,
    input  dma_wr_req_valid,
    output dma_wr_req_ready
  );
endinterface

// File: rtl/nv_nvdla_pdp_wdma_pack.sv
`timescale 1ns/1ps
// PDP write-DMA packer: gathers eight int8 channel bytes into a 64-bit atom, tags it
// with its destination address (base + surf*surface_stride + h*line_stride + w*8,
// built with accumulators) and offers it to the DMA through a one-entry output register.
module nv_nvdla_pdp_wdma_pack (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rstn,
  input  logic                            reg2dp_op_en,
  input  logic [12:0]                     reg2dp_cube_out_width,
  input  logic [12:0]                     reg2dp_cube_out_height,
  input  logic [12:0]                     reg2dp_cube_out_channel,
  input  logic [31:0]                     reg2dp_dst_base_addr,
  input  logic [31:0]                     reg2dp_dst_line_stride,
  input  logic [31:0]                     reg2dp_dst_surface_stride,
  nv_nvdla_pdp_wdma_pack_if.master        bus,
  output logic                            dp2reg_done,
  output logic [1:0]                      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  byte_cnt;
  logic [12:0] w_cnt;
  logic [12:0] h_cnt;
  logic [9:0]  s_cnt;

  // Layer configuration captured on IDLE->RUN so later register writes do not disturb a layer.
  logic [12:0] cfg_w_max;
  logic [12:0] cfg_h_max;
  logic [9:0]  cfg_s_max;
  logic [31:0] cfg_line_stride;
  logic [31:0] cfg_surf_stride;

  // Address accumulators: start of current surface, current line, current atom.
  logic [31:0] surf_addr;
  logic [31:0] line_addr;
  logic [31:0] atom_addr;

  logic [55:0] pack;
  logic        out_valid;
  logic [95:0] out_pd;

  logic in_ready;
  logic accept;
  logic atom_done;
  logic w_last;
  logic h_last;
  logic s_last;
  logic out_accept;

  // Channel LSBs only select a lane inside an atom, which the input order already fixes.
  logic unused_chan_lsb;
  assign unused_chan_lsb = ^reg2dp_cube_out_channel[2:0];

  // Ready depends only on registered state; a full output register blocks only the 8th byte.
  assign in_ready   = (state == RUN) && !((byte_cnt == 3'd7) && out_valid);
  assign accept     = bus.pdp_dp2wdma_valid && in_ready;
  assign atom_done  = accept && (byte_cnt == 3'd7);
  assign w_last     = (w_cnt == cfg_w_max);
  assign h_last     = (h_cnt == cfg_h_max);
  assign s_last     = (s_cnt == cfg_s_max);
  assign out_accept = out_valid && bus.dma_wr_req_ready;

  assign bus.pdp_dp2wdma_ready = in_ready;
  assign bus.dma_wr_req_valid  = out_valid;
  assign bus.dma_wr_req_pd     = out_pd;
  assign dp2reg_done           = (state == DONE);
  assign state_dbg             = state;

  // Layer FSM with configuration capture, cube position counters and address accumulators.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state           <= IDLE;
      byte_cnt        <= 3'd0;
      w_cnt           <= 13'd0;
      h_cnt           <= 13'd0;
      s_cnt           <= 10'd0;
      cfg_w_max       <= 13'd0;
      cfg_h_max       <= 13'd0;
      cfg_s_max       <= 10'd0;
      cfg_line_stride <= 32'd0;
      cfg_surf_stride <= 32'd0;
      surf_addr       <= 32'd0;
      line_addr       <= 32'd0;
      atom_addr       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (reg2dp_op_en) begin
            state           <= RUN;
            byte_cnt        <= 3'd0;
            w_cnt           <= 13'd0;
            h_cnt           <= 13'd0;
            s_cnt           <= 10'd0;
            cfg_w_max       <= reg2dp_cube_out_width;
            cfg_h_max       <= reg2dp_cube_out_height;
            cfg_s_max       <= reg2dp_cube_out_channel[12:3];
            cfg_line_stride <= reg2dp_dst_line_stride;
            cfg_surf_stride <= reg2dp_dst_surface_stride;
            surf_addr       <= reg2dp_dst_base_addr;
            line_addr       <= reg2dp_dst_base_addr;
            atom_addr       <= reg2dp_dst_base_addr;
          end
        end
        RUN: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 3'd1;
          end
          if (atom_done) begin
            if (!w_last) begin
              w_cnt     <= w_cnt + 13'd1;
              atom_addr <= atom_addr + 32'd8;
            end else if (!h_last) begin
              w_cnt     <= 13'd0;
              h_cnt     <= h_cnt + 13'd1;
              line_addr <= line_addr + cfg_line_stride;
              atom_addr <= line_addr + cfg_line_stride;
            end else begin
              w_cnt     <= 13'd0;
              h_cnt     <= 13'd0;
              s_cnt     <= s_cnt + 10'd1;
              surf_addr <= surf_addr + cfg_surf_stride;
              line_addr <= surf_addr + cfg_surf_stride;
              atom_addr <= surf_addr + cfg_surf_stride;
            end
            if (w_last && h_last && s_last) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!out_valid) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte lanes fill the pack register; the 8th byte goes straight into the output register with its address.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pack      <= 56'd0;
      out_valid <= 1'b0;
      out_pd    <= 96'd0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (accept && (byte_cnt == 3'(k))) begin
          pack[k*8 +: 8] <= bus.pdp_dp2wdma_pd;
        end
      end
      if (atom_done) begin
        out_valid <= 1'b1;
        out_pd    <= {bus.pdp_dp2wdma_pd, pack, atom_addr};
      end else if (out_accept) begin
        out_valid <= 1'b0;
        out_pd    <= 96'd0;
      end
    end
  end

endmodule
